trap_controller: RTL and testbench

Sequential machine-mode trap controller for the RV32IMZ core and the successor to the combinational exception unit. It sits at the commit stage and prioritises synchronous exceptions and NUM_IRQ level interrupts at instruction boundaries. It owns the trap CSRs (mstatus.MIE/MPIE, mie, mip, mtvec, mepc, mcause, mtval) and sequences trap entry and MRET return through a small FSM, driving PC redirects and pipeline flushes.

---
 rtl/trap_controller_pkg.sv | 57 +++++
 rtl/trap_prioritiser.sv | 84 ++++++++
 rtl/trap_controller.sv | 212 +++++++++++++++++++++
 tb/tb_trap_controller.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_controller_pkg.sv
// Shared definitions for the machine-mode trap controller: cause codes, CSR
// addresses, FSM state encoding, memory access sizes and the alignment helper.
package trap_controller_pkg;

    // Exception cause codes (mcause with the interrupt flag clear)
    localparam logic [31:0] MCAUSE_INSTR_MISALIGNED = 32'd0;
    localparam logic [31:0] MCAUSE_ILLEGAL_INSTR    = 32'd2;
    localparam logic [31:0] MCAUSE_BREAKPOINT       = 32'd3;
    localparam logic [31:0] MCAUSE_LOAD_MISALIGNED  = 32'd4;
    localparam logic [31:0] MCAUSE_LOAD_ACCESS      = 32'd5;
    localparam logic [31:0] MCAUSE_STORE_MISALIGNED = 32'd6;
    localparam logic [31:0] MCAUSE_STORE_ACCESS     = 32'd7;
    localparam logic [31:0] MCAUSE_ECALL_M          = 32'd11;

    // Platform interrupt line i reports cause MCAUSE_IRQ_BASE + i
    localparam int unsigned MCAUSE_IRQ_BASE = 16;
    localparam logic [31:0] MCAUSE_IRQ_FLAG = 32'h8000_0000;

    // Trap CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    // mstatus bit positions
    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;

    // mem_size encodings; 2'd3 is handled like a word
    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

    // Trap sequencing states
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_ENTER   = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } tc_state_e;

    // True when an access of the given size is not naturally aligned
    function automatic logic addr_misaligned(input logic [1:0] addr_lsb,
                                             input logic [1:0] size);
        logic mis;
        case (size)
            MEM_SIZE_BYTE: mis = 1'b0;
            MEM_SIZE_HALF: mis = addr_lsb[0];
            default:       mis = |addr_lsb;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/trap_prioritiser.sv
// Combinational event detection for the trap controller: picks the single
// highest-priority interrupt or exception and supplies its mcause and mtval.
module trap_prioritiser
    import trap_controller_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic [31:0]        pc_i,
    input  logic [31:0]        instruction_i,
    input  logic [31:0]        mem_addr_i,
    input  logic               mem_read_i,
    input  logic               mem_write_i,
    input  logic [1:0]         mem_size_i,
    input  logic               bus_error_i,
    input  logic               illegal_instr_i,
    input  logic               ecall_i,
    input  logic               ebreak_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_en_i,
    input  logic               global_ie_i,
    output logic               event_valid_o,
    output logic [31:0]        cause_o,
    output logic [31:0]        tval_o
);

    logic [NUM_IRQ-1:0] irq_pending;
    logic               irq_hit;
    logic [4:0]         irq_idx;
    logic               mem_mis;
    logic               load_chk;
    logic               store_chk;

    assign irq_pending = irq_i & irq_en_i;
    assign irq_hit     = global_ie_i & (|irq_pending);
    assign mem_mis     = addr_misaligned(mem_addr_i[1:0], mem_size_i);
    assign load_chk    = mem_read_i;
    assign store_chk   = mem_write_i & ~mem_read_i;

    // Lowest pending interrupt index wins; scanning downwards leaves it last
    always_comb begin
        irq_idx = 5'd0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (irq_pending[i]) begin
                irq_idx = 5'(i);
            end
        end
    end

    // Fixed priority chain, interrupts first
    always_comb begin
        event_valid_o = 1'b1;
        cause_o       = 32'h0;
        tval_o        = 32'h0;
        if (irq_hit) begin
            cause_o = MCAUSE_IRQ_FLAG | 32'(MCAUSE_IRQ_BASE + 32'(irq_idx));
        end else if (pc_i[1:0] != 2'b00) begin
            cause_o = MCAUSE_INSTR_MISALIGNED;
            tval_o  = pc_i;
        end else if (illegal_instr_i) begin
            cause_o = MCAUSE_ILLEGAL_INSTR;
            tval_o  = instruction_i;
        end else if (ebreak_i) begin
            cause_o = MCAUSE_BREAKPOINT;
            tval_o  = pc_i;
        end else if (load_chk && mem_mis) begin
            cause_o = MCAUSE_LOAD_MISALIGNED;
            tval_o  = mem_addr_i;
        end else if (load_chk && bus_error_i) begin
            cause_o = MCAUSE_LOAD_ACCESS;
            tval_o  = mem_addr_i;
        end else if (store_chk && mem_mis) begin
            cause_o = MCAUSE_STORE_MISALIGNED;
            tval_o  = mem_addr_i;
        end else if (store_chk && bus_error_i) begin
            cause_o = MCAUSE_STORE_ACCESS;
            tval_o  = mem_addr_i;
        end else if (ecall_i) begin
            cause_o = MCAUSE_ECALL_M;
        end else begin
            event_valid_o = 1'b0;
        end
    end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap controller: owns the trap CSRs and sequences trap entry
// and MRET return at the commit stage, driving PC redirects and flushes.
// Optional build macro VECTORED_MTVEC_EN enables mtvec vectored mode.
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = 8,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [31:0]        pc,
    input  logic [31:0]        instruction,
    input  logic [31:0]        mem_addr,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [1:0]         mem_size,
    input  logic               bus_error,
    input  logic               illegal_instr,
    input  logic               ecall,
    input  logic               ebreak,
    input  logic               mret,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               csr_we,
    input  logic [11:0]        csr_addr,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    output logic               trap_taken,
    output logic               mret_taken,
    output logic [31:0]        redirect_pc,
    output logic               flush,
    output logic               in_trap
);

    tc_state_e          state_q, state_d;
    logic               trap_taken_q, trap_taken_d;
    logic               mret_taken_q, mret_taken_d;
    logic [31:0]        redirect_q, redirect_d;
    logic               flush_q, flush_d;
    logic               in_trap_q, in_trap_d;

    logic               mstatus_mie_q, mstatus_mie_d;
    logic               mstatus_mpie_q, mstatus_mpie_d;
    logic [NUM_IRQ-1:0] mie_q, mie_d;
    logic [31:0]        mtvec_q, mtvec_d;
    logic [31:0]        mepc_q, mepc_d;
    logic [31:0]        mcause_q, mcause_d;
    logic [31:0]        mtval_q, mtval_d;

    logic               ev_valid;
    logic [31:0]        ev_cause;
    logic [31:0]        ev_tval;
    logic [31:0]        trap_target;

    trap_prioritiser #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio (
        .pc_i            (pc),
        .instruction_i   (instruction),
        .mem_addr_i      (mem_addr),
        .mem_read_i      (mem_read),
        .mem_write_i     (mem_write),
        .mem_size_i      (mem_size),
        .bus_error_i     (bus_error),
        .illegal_instr_i (illegal_instr),
        .ecall_i         (ecall),
        .ebreak_i        (ebreak),
        .irq_i           (irq),
        .irq_en_i        (mie_q),
        .global_ie_i     (mstatus_mie_q),
        .event_valid_o   (ev_valid),
        .cause_o         (ev_cause),
        .tval_o          (ev_tval)
    );

    // Handler entry address for the event currently presented
    always_comb begin
        trap_target = {mtvec_q[31:2], 2'b00};
`ifdef VECTORED_MTVEC_EN
        if (ev_cause[31] && (mtvec_q[1:0] == 2'b01)) begin
            trap_target = {mtvec_q[31:2], 2'b00} + 32'({ev_cause[4:0], 2'b00});
        end
`endif
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            trap_taken_q <= 1'b0;
            mret_taken_q <= 1'b0;
            redirect_q   <= 32'h0;
            flush_q      <= 1'b0;
            in_trap_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            trap_taken_q <= trap_taken_d;
            mret_taken_q <= mret_taken_d;
            redirect_q   <= redirect_d;
            flush_q      <= flush_d;
            in_trap_q    <= in_trap_d;
        end
    end

    // Next state and next output values; commits are only looked at in RUN/HANDLER
    always_comb begin
        state_d      = state_q;
        trap_taken_d = 1'b0;
        mret_taken_d = 1'b0;
        redirect_d   = 32'h0;
        case (state_q)
            ST_RUN, ST_HANDLER: begin
                if (instr_valid && ev_valid) begin
                    state_d      = ST_ENTER;
                    trap_taken_d = 1'b1;
                    redirect_d   = trap_target;
                end else if (instr_valid && mret) begin
                    state_d      = ST_RETURN;
                    mret_taken_d = 1'b1;
                    redirect_d   = mepc_q;
                end
            end
            ST_ENTER:  state_d = ST_HANDLER;
            ST_RETURN: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
        flush_d   = trap_taken_d | mret_taken_d;
        in_trap_d = (state_d == ST_HANDLER);
    end

    // Trap CSR registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= RESET_MTVEC;
            mepc_q         <= 32'h0;
            mcause_q       <= 32'h0;
            mtval_q        <= 32'h0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
        end
    end

    // CSR updates: trap entry / return take precedence and drop a concurrent software write
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        if (trap_taken_d) begin
            mepc_d         = {pc[31:2], 2'b00};
            mcause_d       = ev_cause;
            mtval_d        = ev_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_taken_d) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (csr_we) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = csr_wdata[MSTATUS_MIE_BIT];
                    mstatus_mpie_d = csr_wdata[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:    mie_d    = csr_wdata[MCAUSE_IRQ_BASE +: NUM_IRQ];
`ifdef VECTORED_MTVEC_EN
                CSR_MTVEC:  mtvec_d  = csr_wdata;
`else
                CSR_MTVEC:  mtvec_d  = {csr_wdata[31:2], 2'b00};
`endif
                CSR_MEPC:   mepc_d   = {csr_wdata[31:2], 2'b00};
                CSR_MCAUSE: mcause_d = csr_wdata;
                CSR_MTVAL:  mtval_d  = csr_wdata;
                default: ;
            endcase
        end
    end

    // Combinational CSR read port
    always_comb begin
        csr_rdata = 32'h0;
        case (csr_addr)
            CSR_MSTATUS: csr_rdata = {24'h0, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000};
            CSR_MIE:     csr_rdata = 32'({mie_q, 16'h0000});
            CSR_MTVEC:   csr_rdata = mtvec_q;
            CSR_MEPC:    csr_rdata = mepc_q;
            CSR_MCAUSE:  csr_rdata = mcause_q;
            CSR_MTVAL:   csr_rdata = mtval_q;
            CSR_MIP:     csr_rdata = 32'({irq, 16'h0000});
            default:     csr_rdata = 32'h0;
        endcase
    end

    assign trap_taken  = trap_taken_q;
    assign mret_taken  = mret_taken_q;
    assign redirect_pc = redirect_q;
    assign flush       = flush_q;
    assign in_trap     = in_trap_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed testbench for trap_controller: a table of single-commit vectors
// plus hand-written sequences for MRET, interrupts, collisions and reset.
module tb_trap_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        bus_error;
    logic        illegal_instr;
    logic        ecall;
    logic        ebreak;
    logic        mret;
    logic [7:0]  irq;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        trap_taken;
    logic        mret_taken;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        in_trap;

    int errors = 0;
    int checks = 0;

    trap_controller dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .instruction   (instruction),
        .mem_addr      (mem_addr),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_size      (mem_size),
        .bus_error     (bus_error),
        .illegal_instr (illegal_instr),
        .ecall         (ecall),
        .ebreak        (ebreak),
        .mret          (mret),
        .irq           (irq),
        .csr_we        (csr_we),
        .csr_addr      (csr_addr),
        .csr_wdata     (csr_wdata),
        .csr_rdata     (csr_rdata),
        .trap_taken    (trap_taken),
        .mret_taken    (mret_taken),
        .redirect_pc   (redirect_pc),
        .flush         (flush),
        .in_trap       (in_trap)
    );

    always #10 clk = ~clk;

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        berr;
        logic        ill;
        logic        ec;
        logic        eb;
        logic [7:0]  irq;
        logic        exp_trap;
        logic [31:0] exp_cause;
        logic [31:0] exp_tval;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_csr(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        check(name, csr_rdata, exp);
    endtask

    task automatic clear_inputs();
        instr_valid   = 1'b0;
        pc            = 32'h0;
        instruction   = 32'h0;
        mem_addr      = 32'h0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_size      = 2'd0;
        bus_error     = 1'b0;
        illegal_instr = 1'b0;
        ecall         = 1'b0;
        ebreak        = 1'b0;
        mret          = 1'b0;
    endtask

    // Called at a negedge; returns at a negedge
    task automatic wr_csr(input logic [11:0] a, input logic [31:0] d);
        csr_we    = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
        @(negedge clk);
        csr_we    = 1'b0;
        csr_wdata = 32'h0;
    endtask

    task automatic do_mret(input string name, input logic [31:0] exp_redirect);
        instr_valid = 1'b1;
        mret        = 1'b1;
        @(negedge clk);
        clear_inputs();
        check1({name, ".mret_taken"}, mret_taken, 1'b1);
        check1({name, ".mret_no_trap"}, trap_taken, 1'b0);
        check({name, ".mret_redirect"}, redirect_pc, exp_redirect);
        @(negedge clk);
        check1({name, ".run_in_trap"}, in_trap, 1'b0);
    endtask

    task automatic add_vec(input string name, input logic valid, input logic [31:0] p,
                           input logic [31:0] ins, input logic [31:0] a, input logic rd,
                           input logic wr, input logic [1:0] sz, input logic berr,
                           input logic ill, input logic ec, input logic eb, input logic [7:0] ir,
                           input logic et, input logic [31:0] ecause, input logic [31:0] etval);
        vec_t v;
        v.name = name; v.valid = valid; v.pc = p; v.instr = ins; v.addr = a;
        v.rd = rd; v.wr = wr; v.size = sz; v.berr = berr; v.ill = ill; v.ec = ec;
        v.eb = eb; v.irq = ir; v.exp_trap = et; v.exp_cause = ecause; v.exp_tval = etval;
        vecs.push_back(v);
    endtask

    initial begin
        clear_inputs();
        rst       = 1'b1;
        irq       = 8'h0;
        csr_we    = 1'b0;
        csr_addr  = 12'h0;
        csr_wdata = 32'h0;

        //      name            vld pc            instr         addr          rd wr sz berr ill ec eb irq   trap cause         tval
        add_vec("illegal",      1, 32'h1000, 32'hDEADBEEF, 32'h0,      0, 0, 0, 0, 1, 0, 0, 8'h0, 1, 32'd2,  32'hDEADBEEF);
        add_vec("pc_misalign",  1, 32'h1002, 32'hDEADBEEF, 32'h0,      0, 0, 0, 0, 1, 0, 0, 8'h0, 1, 32'd0,  32'h1002);
        add_vec("ebreak",       1, 32'h1004, 32'h0,        32'h0,      0, 0, 0, 0, 0, 1, 1, 8'h0, 1, 32'd3,  32'h1004);
        add_vec("half_ok",      1, 32'h1008, 32'h0,        32'h3002,   1, 0, 1, 0, 0, 0, 0, 8'h0, 0, 32'd0,  32'h0);
        add_vec("half_mis",     1, 32'h100C, 32'h0,        32'h3001,   1, 0, 1, 0, 0, 0, 0, 8'h0, 1, 32'd4,  32'h3001);
        add_vec("byte_berr",    1, 32'h1010, 32'h0,        32'h3003,   1, 0, 0, 1, 0, 0, 0, 8'h0, 1, 32'd5,  32'h3003);
        add_vec("byte_ok",      1, 32'h1014, 32'h0,        32'h3003,   1, 0, 0, 0, 0, 0, 0, 8'h0, 0, 32'd0,  32'h0);
        add_vec("size3_mis",    1, 32'h1018, 32'h0,        32'h3002,   1, 0, 3, 0, 0, 0, 0, 8'h0, 1, 32'd4,  32'h3002);
        add_vec("store_mis",    1, 32'h101C, 32'h0,        32'h3006,   0, 1, 2, 1, 0, 0, 0, 8'h0, 1, 32'd6,  32'h3006);
        add_vec("store_berr",   1, 32'h1020, 32'h0,        32'h3008,   0, 1, 2, 1, 0, 1, 0, 8'h0, 1, 32'd7,  32'h3008);
        add_vec("ecall",        1, 32'h1024, 32'h0,        32'h0,      0, 0, 0, 0, 0, 1, 0, 8'h0, 1, 32'd11, 32'h0);
        add_vec("ldmis_ecall",  1, 32'h1028, 32'h0,        32'h3001,   1, 0, 2, 0, 0, 1, 0, 8'h0, 1, 32'd4,  32'h3001);
        add_vec("irq_masked",   1, 32'h102C, 32'h0,        32'h0,      0, 0, 0, 0, 0, 0, 0, 8'h1, 0, 32'd0,  32'h0);
        add_vec("not_valid",    0, 32'h1030, 32'h0,        32'h0,      0, 0, 0, 0, 1, 1, 0, 8'h0, 0, 32'd0,  32'h0);

        // Reset state
        repeat (3) @(negedge clk);
        check1("rst.trap_taken", trap_taken, 1'b0);
        check1("rst.flush", flush, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check1("reset.mret_taken", mret_taken, 1'b0);
        check("reset.redirect", redirect_pc, 32'h0);
        check1("reset.in_trap", in_trap, 1'b0);
        chk_csr("reset.mtvec", 12'h305, 32'h0000_0100);
        chk_csr("reset.mstatus", 12'h300, 32'h0);
        chk_csr("reset.mepc", 12'h341, 32'h0);
        chk_csr("reset.mcause", 12'h342, 32'h0);

        // Table of single-commit vectors, each starting from RUN
        foreach (vecs[k]) begin
            instr_valid   = vecs[k].valid;
            pc            = vecs[k].pc;
            instruction   = vecs[k].instr;
            mem_addr      = vecs[k].addr;
            mem_read      = vecs[k].rd;
            mem_write     = vecs[k].wr;
            mem_size      = vecs[k].size;
            bus_error     = vecs[k].berr;
            illegal_instr = vecs[k].ill;
            ecall         = vecs[k].ec;
            ebreak        = vecs[k].eb;
            irq           = vecs[k].irq;
            @(negedge clk);
            clear_inputs();
            irq = 8'h0;
            check1({vecs[k].name, ".trap_taken"}, trap_taken, vecs[k].exp_trap);
            check1({vecs[k].name, ".flush"}, flush, vecs[k].exp_trap);
            if (vecs[k].exp_trap) begin
                check({vecs[k].name, ".redirect"}, redirect_pc, 32'h100);
                chk_csr({vecs[k].name, ".mcause"}, 12'h342, vecs[k].exp_cause);
                chk_csr({vecs[k].name, ".mtval"}, 12'h343, vecs[k].exp_tval);
                chk_csr({vecs[k].name, ".mepc"}, 12'h341, {vecs[k].pc[31:2], 2'b00});
                @(negedge clk);
                check1({vecs[k].name, ".in_trap"}, in_trap, 1'b1);
                check1({vecs[k].name, ".pulse"}, trap_taken, 1'b0);
                do_mret(vecs[k].name, {vecs[k].pc[31:2], 2'b00});
            end else begin
                @(negedge clk);
                check1({vecs[k].name, ".no_in_trap"}, in_trap, 1'b0);
            end
        end

        // MRET restores MIE from MPIE
        wr_csr(12'h300, 32'h8);
        chk_csr("mret.mstatus_set", 12'h300, 32'h8);
        instr_valid = 1'b1; pc = 32'h1000; illegal_instr = 1'b1; instruction = 32'hDEADBEEF;
        @(negedge clk);
        clear_inputs();
        check1("mret.trap", trap_taken, 1'b1);
        chk_csr("mret.mstatus_entry", 12'h300, 32'h80);
        @(negedge clk);
        do_mret("mret", 32'h1000);
        chk_csr("mret.mstatus_ret", 12'h300, 32'h88);

        // Enabled interrupt beats illegal instruction; lowest line wins
        wr_csr(12'h304, 32'h000A_0000);
        wr_csr(12'h305, 32'h0000_0101);
`ifdef VECTORED_MTVEC_EN
        chk_csr("irq.mtvec", 12'h305, 32'h101);
`else
        chk_csr("irq.mtvec", 12'h305, 32'h100);
`endif
        irq = 8'b0000_1010;
        chk_csr("irq.mip", 12'h344, 32'h000A_0000);
        chk_csr("irq.mie", 12'h304, 32'h000A_0000);
        instr_valid = 1'b1; pc = 32'h1100; illegal_instr = 1'b1; instruction = 32'h1234_5678;
        @(negedge clk);
        clear_inputs();
        check1("irq.trap", trap_taken, 1'b1);
`ifdef VECTORED_MTVEC_EN
        check("irq.redirect", redirect_pc, 32'h144);
`else
        check("irq.redirect", redirect_pc, 32'h100);
`endif
        chk_csr("irq.mcause", 12'h342, 32'h8000_0011);
        chk_csr("irq.mtval", 12'h343, 32'h0);
        @(negedge clk);
        // MRET with the interrupt still pending: MIE is 0 in the handler
        do_mret("irq_mret", 32'h1100);
        instr_valid = 1'b1; pc = 32'h1200;
        @(negedge clk);
        clear_inputs();
        check1("irq_again.trap", trap_taken, 1'b1);
        chk_csr("irq_again.mcause", 12'h342, 32'h8000_0011);
        irq = 8'h0;
        @(negedge clk);
        // Exception while in HANDLER re-enters and overwrites mepc
        instr_valid = 1'b1; pc = 32'h7000; ebreak = 1'b1;
        @(negedge clk);
        clear_inputs();
        check1("nested.trap", trap_taken, 1'b1);
        chk_csr("nested.mepc", 12'h341, 32'h7000);
        chk_csr("nested.mcause", 12'h342, 32'd3);
        @(negedge clk);
        do_mret("nested", 32'h7000);
        wr_csr(12'h300, 32'h0);
        wr_csr(12'h304, 32'h0);
        wr_csr(12'h305, 32'h100);

        // CSR write to mepc collides with trap entry update
        instr_valid = 1'b1; pc = 32'h4000; ecall = 1'b1;
        csr_we = 1'b1; csr_addr = 12'h341; csr_wdata = 32'h2000;
        @(negedge clk);
        clear_inputs();
        csr_we = 1'b0;
        check1("collide.trap", trap_taken, 1'b1);
        chk_csr("collide.mepc", 12'h341, 32'h4000);
        @(negedge clk);
        wr_csr(12'h341, 32'h2003);
        chk_csr("collide.mepc_wr", 12'h341, 32'h2000);
        do_mret("collide", 32'h2000);

        // Reset asserted while in ENTER
        wr_csr(12'h305, 32'h200);
        instr_valid = 1'b1; pc = 32'h5000; ecall = 1'b1;
        @(negedge clk);
        clear_inputs();
        check1("rst_enter.trap", trap_taken, 1'b1);
        check("rst_enter.redirect_pre", redirect_pc, 32'h200);
        rst = 1'b1;
        #1;
        check1("rst_enter.trap_taken", trap_taken, 1'b0);
        check1("rst_enter.flush", flush, 1'b0);
        check("rst_enter.redirect", redirect_pc, 32'h0);
        check1("rst_enter.in_trap", in_trap, 1'b0);
        chk_csr("rst_enter.mtvec", 12'h305, 32'h100);
        chk_csr("rst_enter.mepc", 12'h341, 32'h0);
        chk_csr("rst_enter.mcause", 12'h342, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check1("rst_enter.run", in_trap, 1'b0);
        instr_valid = 1'b1; pc = 32'h6000; ecall = 1'b1;
        @(negedge clk);
        clear_inputs();
        check1("post_rst.trap", trap_taken, 1'b1);
        check("post_rst.redirect", redirect_pc, 32'h100);
        chk_csr("post_rst.mcause", 12'h342, 32'd11);
        @(negedge clk);
        do_mret("post_rst", 32'h6000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
